mem_port_responder: RTL and testbench

- Data-memory responder serving the multicycle control unit's load/store requests over a valid/ready request channel and a one-cycle response strobe.
- Holds an internal word array and models a fixed access latency.
- Handles byte, half and word accesses with little-endian lane steering and sign/zero extension.
- Flags misaligned, out-of-range and illegal-size accesses.
- Replaces direct combinational memory access so the control FSM waits on resp_valid instead of fixed cycle counts.

---
 rtl/mem_port_responder.sv | 192 +++++++++++++++++++
 tb/tb_mem_port_responder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_responder.sv
// Data-memory responder: valid/ready request in, one-cycle response strobe out.
// Fixed-latency word array with byte/half/word lanes, extension and error flags.
// Ports:
//   clk, rst          : clock, async active-high reset
//   req_valid/ready   : request handshake (ready only while idle)
//   req_write         : 1=store, 0=load
//   req_addr          : byte address, word index is req_addr[31:2]
//   req_wdata         : right-aligned store data
//   req_size          : 00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned      : loads zero-extend when set, sign-extend otherwise
//   resp_valid        : one-cycle completion pulse
//   resp_rdata        : load result (0 for stores and errors)
//   resp_err          : access error, valid with resp_valid
//   busy              : request in flight
module mem_port_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state;
    logic [3:0]  cnt;

    logic        rWrite;
    logic [31:0] rAddr;
    logic [31:0] rWdata;
    logic [1:0]  rSize;
    logic        rUnsigned;

    logic [31:0] mem [DEPTH];

    // With LATENCY=1 the response is formed on the acceptance edge itself,
    // so the access fields come straight from the port while idle.
    logic        sWrite;
    logic [31:0] sAddr;
    logic [31:0] sWdata;
    logic [1:0]  sSize;
    logic        sUnsigned;

    logic          err;
    logic [IW-1:0] idx;
    logic [31:0]   word;
    logic [7:0]    byteVal;
    logic [15:0]   halfVal;
    logic [31:0]   loadData;
    logic [31:0]   wrWord;
    logic [31:0]   respData;

    always_comb begin
        if (state == IDLE) begin
            sWrite    = req_write;
            sAddr     = req_addr;
            sWdata    = req_wdata;
            sSize     = req_size;
            sUnsigned = req_unsigned;
        end else begin
            sWrite    = rWrite;
            sAddr     = rAddr;
            sWdata    = rWdata;
            sSize     = rSize;
            sUnsigned = rUnsigned;
        end
    end

    always_comb begin
        err = (sSize == 2'b11)
            | ((sSize == 2'b01) & sAddr[0])
            | ((sSize == 2'b10) & (sAddr[1:0] != 2'b00))
            | (sAddr[31:2] >= 30'(DEPTH));
        idx  = sAddr[IW+1:2];
        word = mem[idx];
    end

    always_comb begin
        byteVal = word[7:0];
        case (sAddr[1:0])
            2'b00:   byteVal = word[7:0];
            2'b01:   byteVal = word[15:8];
            2'b10:   byteVal = word[23:16];
            default: byteVal = word[31:24];
        endcase
        halfVal = sAddr[1] ? word[31:16] : word[15:0];
        case (sSize)
            2'b00:   loadData = {{24{~sUnsigned & byteVal[7]}}, byteVal};
            2'b01:   loadData = {{16{~sUnsigned & halfVal[15]}}, halfVal};
            default: loadData = word;
        endcase
        respData = (err | sWrite) ? 32'h0 : loadData;
    end

    // Merge store data into the current word; untouched lanes keep old bytes.
    always_comb begin
        wrWord = word;
        case (sSize)
            2'b00: begin
                case (sAddr[1:0])
                    2'b00:   wrWord[7:0]   = sWdata[7:0];
                    2'b01:   wrWord[15:8]  = sWdata[7:0];
                    2'b10:   wrWord[23:16] = sWdata[7:0];
                    default: wrWord[31:24] = sWdata[7:0];
                endcase
            end
            2'b01: begin
                if (sAddr[1]) wrWord[31:16] = sWdata[15:0];
                else          wrWord[15:0]  = sWdata[15:0];
            end
            default: wrWord = sWdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            rWrite     <= 1'b0;
            rAddr      <= 32'h0;
            rWdata     <= 32'h0;
            rSize      <= 2'b00;
            rUnsigned  <= 1'b0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        rWrite    <= req_write;
                        rAddr     <= req_addr;
                        rWdata    <= req_wdata;
                        rSize     <= req_size;
                        rUnsigned <= req_unsigned;
                        cnt       <= 4'(LATENCY - 1);
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (LATENCY > 1) begin
                            state <= WAIT;
                        end else begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= err;
                            resp_rdata <= respData;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= err;
                        resp_rdata <= respData;
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'h0;
                    req_ready  <= 1'b1;
                    busy       <= 1'b0;
                    if (rWrite && !err) mem[idx] <= wrWord;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_responder.sv
// Testbench for mem_port_responder: vector table through a response scoreboard,
// plus back-pressure and reset-abort sequences.
module tb_mem_port_responder;

    localparam int DEPTH = 64;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;

    mem_port_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] expRdata;
        logic        expErr;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t monE;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   pulses = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (resp_valid) begin
                pulses++;
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_resp: got pulse at cycle %0d expected none", cyc);
                end else begin
                    monE = sb.pop_front();
                    chk("resp_rdata", resp_rdata, monE.rdata);
                    chk("resp_err", 32'(resp_err), 32'(monE.err));
                    chk("latency", 32'(cyc - monE.cyc), 32'(LAT));
                end
            end else begin
                chk("idle_resp_rdata", resp_rdata, 32'h0);
                chk("idle_resp_err", 32'(resp_err), 32'h0);
            end
        end
    end

    task automatic waitDrain();
        int k = 0;
        while (sb.size() != 0 && k < 30) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("drain_timeout", 32'(sb.size()), 32'h0);
    endtask

    task automatic drive(input vec_t v);
        req_write    = v.write;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
        req_size     = v.size;
        req_unsigned = v.uns;
    endtask

    task automatic doReq(input vec_t v);
        int k = 0;
        @(negedge clk);
        drive(v);
        req_valid = 1'b1;
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("accept_timeout", 32'(req_ready), 32'h1);
        if (req_ready) begin
            sb.push_back('{v.expRdata, v.expErr, cyc});
            @(negedge clk);
            req_valid = 1'b0;
            chk("wait_ready", 32'(req_ready), 32'h0);
            chk("wait_busy", 32'(busy), 32'h1);
            waitDrain();
        end else begin
            req_valid = 1'b0;
        end
    endtask

    vec_t vecs[$];

    initial begin
        int p0;
        int acc;
        int lastAcc;
        int k;
        vec_t v;

        vecs.push_back('{0, 32'h00, 32'h0,        2'b10, 0, 32'h00000000, 0});
        vecs.push_back('{1, 32'h10, 32'hDEADBEEF, 2'b10, 0, 32'h00000000, 0});
        vecs.push_back('{0, 32'h10, 32'h0,        2'b10, 0, 32'hDEADBEEF, 0});
        vecs.push_back('{1, 32'h11, 32'hFFFFFF5A, 2'b00, 0, 32'h00000000, 0});
        vecs.push_back('{0, 32'h10, 32'h0,        2'b10, 0, 32'hDEAD5AEF, 0});
        vecs.push_back('{0, 32'h12, 32'h0,        2'b01, 0, 32'hFFFFDEAD, 0});
        vecs.push_back('{0, 32'h13, 32'h0,        2'b00, 1, 32'h000000DE, 0});
        vecs.push_back('{0, 32'h10, 32'h0,        2'b00, 0, 32'hFFFFFFEF, 0});
        vecs.push_back('{0, 32'h12, 32'h0,        2'b01, 1, 32'h0000DEAD, 0});
        vecs.push_back('{0, 32'h11, 32'h0,        2'b00, 1, 32'h0000005A, 0});
        vecs.push_back('{0, 32'h12, 32'h0,        2'b10, 0, 32'h00000000, 1});
        vecs.push_back('{0, 32'h13, 32'h0,        2'b01, 0, 32'h00000000, 1});
        vecs.push_back('{0, 32'h10, 32'h0,        2'b11, 0, 32'h00000000, 1});
        vecs.push_back('{0, 32'h100, 32'h0,       2'b10, 0, 32'h00000000, 1});
        vecs.push_back('{1, 32'h102, 32'h1234,    2'b10, 0, 32'h00000000, 1});
        vecs.push_back('{1, 32'h12, 32'h0, 2'b11, 0, 32'h00000000, 1});
        vecs.push_back('{0, 32'h100, 32'h0,       2'b10, 0, 32'h00000000, 1});
        vecs.push_back('{0, 32'h10, 32'h0,        2'b10, 0, 32'hDEAD5AEF, 0});
        vecs.push_back('{1, 32'h12, 32'h1234BEEF, 2'b01, 0, 32'h00000000, 0});
        vecs.push_back('{0, 32'h10, 32'h0,        2'b10, 0, 32'hBEEF5AEF, 0});
        vecs.push_back('{1, 32'hFC, 32'h11223344, 2'b10, 0, 32'h00000000, 0});
        vecs.push_back('{0, 32'hFC, 32'h0,        2'b10, 0, 32'h11223344, 0});
        vecs.push_back('{0, 32'hFF, 32'h0,        2'b00, 0, 32'h00000011, 0});

        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'h1);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_valid", 32'(resp_valid), 32'h0);
        chk("rst_rdata", resp_rdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", 32'(req_ready), 32'h1);

        foreach (vecs[i]) doReq(vecs[i]);

        // Back-pressure: three loads with req_valid held high throughout.
        @(negedge clk);
        v = '{0, 32'hFC, 32'h0, 2'b10, 0, 32'h11223344, 0};
        drive(v);
        req_valid = 1'b1;
        p0 = pulses;
        acc = 0;
        lastAcc = 0;
        k = 0;
        while (acc < 3 && k < 40) begin
            if (req_ready) begin
                sb.push_back('{v.expRdata, v.expErr, cyc});
                if (acc > 0) chk("bp_spacing", 32'(cyc - lastAcc), 32'(LAT + 1));
                lastAcc = cyc;
                acc++;
            end
            if (acc < 3) begin
                @(negedge clk);
                k++;
            end
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("bp_accepts", 32'(acc), 32'h3);
        waitDrain();
        repeat (3) @(negedge clk);
        chk("bp_pulses", 32'(pulses - p0), 32'h3);

        // Reset during WAIT aborts the store with no response pulse.
        p0 = pulses;
        @(negedge clk);
        drive('{1, 32'h20, 32'hCAFEF00D, 2'b10, 0, 32'h0, 0});
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort_in_wait", 32'(busy), 32'h1);
        rst = 1'b1;
        #1;
        chk("abort_rst_valid", 32'(resp_valid), 32'h0);
        chk("abort_rst_ready", 32'(req_ready), 32'h1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_no_pulse", 32'(pulses - p0), 32'h0);
        doReq('{0, 32'h20, 32'h0, 2'b10, 0, 32'h00000000, 0});
        doReq('{0, 32'hFC, 32'h0, 2'b10, 0, 32'h00000000, 0});

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
